deck_manager: RTL and testbench

Owns the 52-card deck for the blackjack datapath: on reset it loads an ordered deck and shuffles it with a 6-bit LFSR. It then serves one-card draw requests from the player and dealer paths under round-robin arbitration. It sits between the game controller (which raises `req_player`/`req_dealer`/`shuffle`) and the score/display logic (which consumes `card`, `rank`, `points`).

---
 rtl/deck_manager.sv | 161 ++++++++++++++++
 tb/tb_deck_manager.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_manager.sv
// 52-card deck owner: ordered load, LFSR swap shuffle, round-robin player/dealer draws.
// Optional build macro DECK_AUTO_RESHUFFLE_EN: an emptied deck reshuffles itself instead of waiting for `shuffle`.
module deck_manager #(
    parameter logic [5:0] SEED   = 6'b011110,
    parameter int         PASSES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_player,
    input  logic       req_dealer,
    input  logic       shuffle,
    output logic [5:0] card,
    output logic [3:0] rank,
    output logic [3:0] points,
    output logic       card_to,
    output logic       card_valid,
    output logic       ready,
    output logic       empty,
    output logic [5:0] cards_left,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        SHUFFLE = 3'd1,
        READY   = 3'd2,
        DEAL    = 3'd3
    } state_t;

    localparam logic [5:0] SEED_EFF  = (SEED == 6'd0) ? 6'd1 : SEED;
    localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

    state_t     st, st_nxt;
    logic [5:0] deck [0:51];
    logic [5:0] lfsr;
    logic [5:0] idx;
    logic [5:0] ptr;
    logic [5:0] j;
    logic [1:0] pass;
    logic       last;
    logic       grant;
    logic       grant_to;
    logic       do_shuffle;
    logic       end_init;
    logic       end_shuffle;

    function automatic logic [3:0] card_rank(input logic [5:0] c);
        return 4'((c % 6'd13) + 6'd1);
    endfunction

    function automatic logic [3:0] cap_points(input logic [3:0] r);
        return (r > 4'd10) ? 4'd10 : r;
    endfunction

    // Fold the 1..63 LFSR range onto a deck slot.
    assign j           = (lfsr >= 6'd52) ? (lfsr - 6'd52) : lfsr;
    assign end_init    = (idx == 6'd51);
    assign end_shuffle = (idx == 6'd51) && (pass == LAST_PASS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= INIT;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt     = st;
        grant      = 1'b0;
        grant_to   = 1'b0;
        do_shuffle = 1'b0;
        case (st)
            INIT:    if (end_init) st_nxt = SHUFFLE;
            SHUFFLE: if (end_shuffle) st_nxt = READY;
            READY: begin
                if (shuffle) begin
                    do_shuffle = 1'b1;
                    st_nxt     = SHUFFLE;
                end else if (!empty) begin
                    if (req_player && req_dealer) begin
                        grant    = 1'b1;
                        grant_to = ~last;
                    end else if (req_player || req_dealer) begin
                        grant    = 1'b1;
                        grant_to = req_dealer;
                    end
                    if (grant) st_nxt = DEAL;
                end
            end
            DEAL: begin
`ifdef DECK_AUTO_RESHUFFLE_EN
                if (ptr == 6'd51) st_nxt = SHUFFLE;
                else              st_nxt = READY;
`else
                st_nxt = READY;
`endif
            end
            default: st_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr    <= SEED_EFF;
            idx     <= 6'd0;
            pass    <= 2'd0;
            ptr     <= 6'd0;
            last    <= 1'b1;
            card    <= 6'd0;
            card_to <= 1'b0;
        end else begin
            lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
            case (st)
                INIT: idx <= end_init ? 6'd0 : idx + 6'd1;
                SHUFFLE: begin
                    // ptr clears here so an auto-reshuffle shows empty for exactly one cycle.
                    ptr <= 6'd0;
                    if (idx == 6'd51) begin
                        idx  <= 6'd0;
                        pass <= end_shuffle ? 2'd0 : pass + 2'd1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                READY: begin
                    if (do_shuffle) begin
                        idx  <= 6'd0;
                        pass <= 2'd0;
                        ptr  <= 6'd0;
                    end else if (grant) begin
                        card    <= deck[ptr];
                        card_to <= grant_to;
                    end
                end
                DEAL: begin
                    ptr  <= ptr + 6'd1;
                    last <= card_to;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (st)
            INIT: deck[idx] <= idx;
            SHUFFLE: begin
                deck[idx] <= deck[j];
                deck[j]   <= deck[idx];
            end
            default: ;
        endcase
    end

    assign card_valid = (st == DEAL);
    assign ready      = (st == READY);
    assign empty      = (ptr == 6'd52);
    assign cards_left = 6'd52 - ptr;
    assign state      = st;
    assign rank       = card_rank(card);
    assign points     = cap_points(rank);

endmodule

// File: tb/tb_deck_manager.sv
// Directed/randomized bench for deck_manager: timing, permutation, round-robin, empty, reset replay.
module tb_deck_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_player, req_dealer, shuffle;
    logic [5:0] card;
    logic [3:0] rank, points;
    logic       card_to, card_valid, ready, empty;
    logic [5:0] cards_left;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    int  n;
    bit  seen [0:51];
    int  order1 [0:51];
    bit  exp_last;

    deck_manager dut (
        .clk(clk), .rst(rst), .req_player(req_player), .req_dealer(req_dealer),
        .shuffle(shuffle), .card(card), .rank(rank), .points(points),
        .card_to(card_to), .card_valid(card_valid), .ready(ready), .empty(empty),
        .cards_left(cards_left), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_state", 32'(state), 0);
        chk("rst_card", 32'(card), 0);
        chk("rst_valid", 32'(card_valid), 0);
        chk("rst_card_to", 32'(card_to), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_empty", 32'(empty), 0);
        chk("rst_left", 32'(cards_left), 52);
        chk("rst_rank", 32'(rank), 1);
        chk("rst_points", 32'(points), 1);
    endtask

    // Called right after rst is released: 52 INIT cycles, 104 SHUFFLE cycles, then READY.
    task automatic init_timing();
        for (int c = 1; c <= 156; c++) begin
            step();
            if (c == 1 || c == 51) chk("init_state", 32'(state), 0);
            if (c == 52 || c == 155) chk("shuf_state", 32'(state), 1);
            if (c == 155) chk("not_ready_155", 32'(ready), 0);
        end
        chk("ready_156", 32'(ready), 1);
        chk("state_156", 32'(state), 2);
        chk("left_156", 32'(cards_left), 52);
        chk("empty_156", 32'(empty), 0);
    endtask

    // Checks a strobe cycle against the model and records the card.
    task automatic check_card(input bit to);
        int c;
        int r;
        c = int'(card);
        r = (c % 13) + 1;
        chk("valid", 32'(card_valid), 1);
        chk("card_to", 32'(card_to), 32'(to));
        chk("card_range", 32'(c < 52), 1);
        if (c < 52) begin
            chk("card_unique", 32'(seen[c]), 0);
            seen[c] = 1'b1;
        end
        chk("rank", 32'(rank), 32'(r));
        chk("points", 32'(points), 32'((r > 10) ? 10 : r));
        order1[n] = c;
        n++;
        exp_last = to;
    endtask

    task automatic after_deal();
`ifdef DECK_AUTO_RESHUFFLE_EN
        if (n == 52) begin
            chk("auto_state", 32'(state), 1);
            chk("auto_empty_pulse", 32'(empty), 1);
            chk("auto_left0", 32'(cards_left), 0);
            return;
        end
`endif
        chk("back_ready", 32'(ready), 1);
        chk("left", 32'(cards_left), 32'(52 - n));
        chk("empty_flag", 32'(empty), 32'(n == 52));
    endtask

    task automatic draw_one(input bit p, input bit d);
        bit to;
        to = (p && d) ? ~exp_last : d;
        req_player = p;
        req_dealer = d;
        step();
        check_card(to);
        req_player = 1'b0;
        req_dealer = 1'b0;
        step();
        after_deal();
    endtask

    initial begin
        int p;
        int cnt;
        bit ident;
        rst = 1'b0;
        req_player = 1'b0;
        req_dealer = 1'b0;
        shuffle = 1'b0;
        n = 0;
        exp_last = 1'b1;
        for (int k = 0; k < 52; k++) seen[k] = 1'b0;

        step();
        step();
        chk_reset_outputs();
        rst = 1'b1;
        init_timing();

        // Player alone, then a tie: the dealer must win it.
        draw_one(1'b1, 1'b0);
        draw_one(1'b1, 1'b1);
        chk("rr_after_player", 32'(card_to), 1);

        // Both held through DEAL: alternating grants every second cycle.
        req_player = 1'b1;
        req_dealer = 1'b1;
        for (int s = 0; s < 8; s++) begin
            step();
            if (s % 2 == 0) check_card(~exp_last);
            else begin
                chk("held_gap_valid", 32'(card_valid), 0);
                chk("held_gap_ready", 32'(ready), 1);
                chk("held_left", 32'(cards_left), 32'(52 - n));
            end
        end
        req_player = 1'b0;
        req_dealer = 1'b0;

        while (n < 52) begin
            p = int'($urandom_range(0, 3));
            if (p == 0) begin
                step();
                chk("idle_no_valid", 32'(card_valid), 0);
            end else begin
                draw_one(p[0], p[1]);
            end
        end

        ident = 1'b1;
        for (int k = 0; k < 52; k++) if (order1[k] != k) ident = 1'b0;
        chk("shuffled_order", 32'(ident), 0);

`ifdef DECK_AUTO_RESHUFFLE_EN
        req_dealer = 1'b1;
        step();
        chk("auto_empty_gone", 32'(empty), 0);
        chk("auto_still_shuffle", 32'(state), 1);
        cnt = 1;
        while (!card_valid && cnt < 300) begin
            step();
            cnt++;
        end
        chk("auto_serve_found", 32'(card_valid), 1);
        chk("auto_serve_latency", 32'(cnt), 105);
        chk("auto_serve_to", 32'(card_to), 1);
        chk("auto_serve_left", 32'(cards_left), 52);
        req_dealer = 1'b0;
        step();
        chk("auto_ready", 32'(ready), 1);
`else
        req_player = 1'b1;
        req_dealer = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("empty_no_valid", 32'(card_valid), 0);
            chk("empty_stays", 32'(empty), 1);
            chk("empty_left0", 32'(cards_left), 0);
        end
        req_player = 1'b0;
        shuffle = 1'b1;
        step();
        shuffle = 1'b0;
        req_dealer = 1'b0;
        chk("reshuf_state", 32'(state), 1);
        chk("reshuf_no_valid", 32'(card_valid), 0);
        chk("reshuf_left", 32'(cards_left), 52);
        for (int c = 2; c <= 104; c++) begin
            step();
            if (c == 104) chk("reshuf_not_ready", 32'(ready), 0);
        end
        step();
        chk("reshuf_ready", 32'(ready), 1);
        chk("reshuf_left_full", 32'(cards_left), 52);
`endif

        // shuffle and a request together: shuffle wins, no strobe.
        shuffle = 1'b1;
        req_dealer = 1'b1;
        step();
        shuffle = 1'b0;
        req_dealer = 1'b0;
        chk("sim_state", 32'(state), 1);
        chk("sim_no_valid", 32'(card_valid), 0);
        chk("sim_left", 32'(cards_left), 52);
        for (int s = 0; s < 10; s++) step();
        chk("mid_shuffle", 32'(state), 1);

        rst = 1'b0;
        #1;
        chk_reset_outputs();
        step();
        chk_reset_outputs();
        rst = 1'b1;
        init_timing();

        // Fresh reset must reproduce the first deck order; player held continuously.
        req_player = 1'b1;
        for (int s = 1; s <= 104; s++) begin
            step();
            if (s % 2 == 1) begin
                chk("replay_valid", 32'(card_valid), 1);
                chk("replay_card", 32'(card), 32'(order1[(s - 1) / 2]));
                chk("replay_to", 32'(card_to), 0);
            end else begin
                chk("replay_gap", 32'(card_valid), 0);
            end
        end
        req_player = 1'b0;
`ifdef DECK_AUTO_RESHUFFLE_EN
        chk("replay_end_state", 32'(state), 1);
        chk("replay_end_empty", 32'(empty), 1);
`else
        chk("replay_end_empty", 32'(empty), 1);
        chk("replay_end_left", 32'(cards_left), 0);
        chk("replay_end_ready", 32'(ready), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
